// File: rtl/wb_pkg.sv
// Shared layout definitions for the writeback/retire slice.
// A lane inside MEM_to_WB_bus is packed {lane_v, gr_we, dest[4:0], result, pc}
// with pc in the LSBs. A trace FIFO entry is packed {pc, we, dest[4:0], result}
// with result in the LSBs. Widths depend on XLEN, so they are exposed as
// constant functions rather than fixed localparams.
package wb_pkg;

    localparam int LANE_OFF_PC = 0;
    localparam int TR_OFF_RESULT = 0;

    function automatic int lane_w(input int xlen);
        return 2 * xlen + 7;
    endfunction

    function automatic int lane_off_result(input int xlen);
        return xlen;
    endfunction

    function automatic int lane_off_dest(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int lane_off_grwe(input int xlen);
        return 2 * xlen + 5;
    endfunction

    function automatic int lane_off_lanev(input int xlen);
        return 2 * xlen + 6;
    endfunction

    // Trace entry: result + dest + we + pc = 2*XLEN + 6 bits.
    function automatic int trace_w(input int xlen);
        return 2 * xlen + 6;
    endfunction

    function automatic int tr_off_dest(input int xlen);
        return xlen;
    endfunction

    function automatic int tr_off_we(input int xlen);
        return xlen + 5;
    endfunction

    function automatic int tr_off_pc(input int xlen);
        return xlen + 6;
    endfunction

endpackage

// File: rtl/wb_retire_stage_if.sv
// MEM -> WB handshake bundle.
//   MEM_to_WB_valid : MEM bundle valid (master -> slave)
//   MEM_to_WB_bus   : LANES packed lanes, lane 0 in the LSBs (master -> slave)
//   WB_flush        : drop the bundle held in WB (master -> slave)
//   WB_allow        : WB accepts a bundle this cycle (slave -> master)
interface wb_retire_stage_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 32
);
    import wb_pkg::*;

    logic                             MEM_to_WB_valid;
    logic [LANES*lane_w(XLEN)-1:0]    MEM_to_WB_bus;
    logic                             WB_flush;
    logic                             WB_allow;

    modport master (
        output MEM_to_WB_valid,
        output MEM_to_WB_bus,
        output WB_flush,
        input  WB_allow
    );

    modport slave (
        input  MEM_to_WB_valid,
        input  MEM_to_WB_bus,
        input  WB_flush,
        output WB_allow
    );

endinterface

// File: rtl/wb_trace_fifo.sv
// Debug trace FIFO: up to LANES pushes per cycle, one pop per cycle.
//   clk, resetn : clock, async active-low reset (pointers and count only)
//   push_v      : per-lane push strobe; valid lanes are packed in lane order
//   push_data   : per-lane entry
//   pop         : remove head (caller guarantees count != 0)
//   head        : entry at the read pointer
//   count       : number of stored entries
// The caller guarantees free space >= number of pushes; no overflow check here.
module wb_trace_fifo #(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int W     = 70
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [LANES-1:0]               push_v,
    input  logic [LANES-1:0][W-1:0]        push_data,
    input  logic                           pop,
    output logic [W-1:0]                   head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PMASK = AW'(DEPTH - 1);

    logic [W-1:0]              mem [DEPTH];
    logic [AW-1:0]             wptr, rptr;
    logic [LANES-1:0][AW-1:0]  slot;
    logic [CW-1:0]             npush;

    // Valid lanes are compacted: each one lands after the valid lanes below it,
    // so a bundle with only lane 1 valid still writes at wptr.
    always_comb begin
        npush = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = (wptr + AW'(npush)) & PMASK;
            npush   = npush + CW'(push_v[i]);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_v[i]) mem[slot[i]] <= push_data[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= (wptr + AW'(npush)) & PMASK;
            if (pop) rptr <= (rptr + AW'(1)) & PMASK;
            count <= count + npush - CW'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback / retire stage: holds one MEM bundle of up to LANES instructions,
// writes the register file when it fires and records every retired lane in a
// debug trace FIFO.
//   clk, resetn        : clock, async active-low reset
//   mem_wb             : MEM -> WB handshake (valid, bus, flush, allow)
//   rf_we/waddr/wdata  : per-lane register-file write port
//   WB_to_ID_forward   : per-lane {gr_we, dest (0 when not valid), result}
//   debug_wb_*         : trace FIFO head with valid/ready handshake
// A bundle fires only when the trace FIFO can take all its valid lanes, so
// a stalled trace consumer back-pressures the pipeline.
module wb_retire_stage
    import wb_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    wb_retire_stage_if.slave          mem_wb,
    output logic [LANES-1:0]          rf_we,
    output logic [LANES*5-1:0]        rf_waddr,
    output logic [LANES*XLEN-1:0]     rf_wdata,
    output logic [LANES*(6+XLEN)-1:0] WB_to_ID_forward,
    output logic                      debug_wb_valid,
    input  logic                      debug_wb_ready,
    output logic [XLEN-1:0]           debug_wb_pc,
    output logic [3:0]                debug_wb_rf_we,
    output logic [4:0]                debug_wb_rf_wnum,
    output logic [XLEN-1:0]           debug_wb_rf_wdata
);
    localparam int LW = lane_w(XLEN);
    localparam int TW = trace_w(XLEN);
    localparam int CW = $clog2(TRACE_DEPTH + 1);

    logic                         wb_valid;
    logic [LANES*LW-1:0]          bundle;
    logic [LANES-1:0]             lane_v, gr_we, wr_ok;
    logic [LANES-1:0][4:0]        dest;
    logic [LANES-1:0][XLEN-1:0]   result, pc;
    logic [LANES-1:0]             push_v;
    logic [LANES-1:0][TW-1:0]     push_data;
    logic [TW-1:0]                head;
    logic [CW-1:0]                fifo_count, nv, free_slots;
    logic                         ready_go, fire, accept, pop;

    // ---- bundle field decode --------------------------------------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int B = g * LW;
        assign pc[g]     = bundle[B + LANE_OFF_PC +: XLEN];
        assign result[g] = bundle[B + lane_off_result(XLEN) +: XLEN];
        assign dest[g]   = bundle[B + lane_off_dest(XLEN) +: 5];
        assign gr_we[g]  = bundle[B + lane_off_grwe(XLEN)];
        assign lane_v[g] = bundle[B + lane_off_lanev(XLEN)];

        assign rf_waddr[g*5 +: 5]       = dest[g];
        assign rf_wdata[g*XLEN +: XLEN] = result[g];

        // Forwarding stays live while the bundle is stalled in WB.
        assign WB_to_ID_forward[g*(6+XLEN) +: 6+XLEN] =
            {gr_we[g], (wb_valid && lane_v[g]) ? dest[g] : 5'd0, result[g]};

        assign push_v[g]    = fire && lane_v[g];
        assign push_data[g] = {pc[g], gr_we[g] && (dest[g] != 5'd0), dest[g], result[g]};
    end

    // ---- handshake --------------------------------------------------------
    always_comb begin
        nv = '0;
        for (int i = 0; i < LANES; i++) nv = nv + CW'(lane_v[i]);
    end

    // Space is judged on the count before this cycle's pop.
    assign free_slots      = CW'(TRACE_DEPTH) - fifo_count;
    assign ready_go        = free_slots >= nv;
    assign mem_wb.WB_allow = !wb_valid || (ready_go && !mem_wb.WB_flush);
    assign fire            = wb_valid && ready_go && !mem_wb.WB_flush;
    assign accept          = mem_wb.MEM_to_WB_valid && mem_wb.WB_allow;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                      wb_valid <= 1'b0;
        else if (accept)                  wb_valid <= 1'b1;
        else if (fire || mem_wb.WB_flush) wb_valid <= 1'b0;
    end

    // Payload register is intentionally not reset; wb_valid qualifies it.
    always_ff @(posedge clk) begin
        if (accept) bundle <= mem_wb.MEM_to_WB_bus;
    end

    // ---- register-file write enables --------------------------------------
    // An older lane is suppressed when any younger lane writes the same
    // register, so the youngest result is the one that lands.
    always_comb begin
        for (int i = 0; i < LANES; i++)
            wr_ok[i] = lane_v[i] && gr_we[i] && (dest[i] != 5'd0);
        for (int i = 0; i < LANES; i++) begin
            rf_we[i] = fire && wr_ok[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (wr_ok[j] && (dest[j] == dest[i])) rf_we[i] = 1'b0;
            end
        end
    end

    // ---- debug trace --------------------------------------------------------
    wb_trace_fifo #(
        .LANES (LANES),
        .DEPTH (TRACE_DEPTH),
        .W     (TW)
    ) u_trace_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push_v    (push_v),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign debug_wb_valid = fifo_count != '0;
    assign pop            = debug_wb_valid && debug_wb_ready;

    // Head fields are forced to zero while empty so stale storage never leaks.
    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_we    = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (debug_wb_valid) begin
            debug_wb_pc       = head[tr_off_pc(XLEN) +: XLEN];
            debug_wb_rf_we    = {4{head[tr_off_we(XLEN)]}};
            debug_wb_rf_wnum  = head[tr_off_dest(XLEN) +: 5];
            debug_wb_rf_wdata = head[TR_OFF_RESULT +: XLEN];
        end
    end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: a vector table for single-bundle behaviour plus
// hand-written stall, flush and reset sequences. RF writes and trace entries
// are predicted into queues when a bundle is driven and checked by monitors.
module tb_wb_retire_stage;
    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
    } lane_t;

    typedef struct {
        lane_t      l0;
        lane_t      l1;
        logic [1:0] exp_we;
    } vec_t;

    typedef struct packed {
        logic [1:0]  we;
        logic [9:0]  addr;
        logic [63:0] data;
    } rf_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
    } tr_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic debug_wb_ready = 1'b0;
    logic [LANES-1:0]          rf_we;
    logic [LANES*5-1:0]        rf_waddr;
    logic [LANES*XLEN-1:0]     rf_wdata;
    logic [LANES*(6+XLEN)-1:0] WB_to_ID_forward;
    logic                      debug_wb_valid;
    logic [XLEN-1:0]           debug_wb_pc;
    logic [3:0]                debug_wb_rf_we;
    logic [4:0]                debug_wb_rf_wnum;
    logic [XLEN-1:0]           debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_retire_stage_if #(.LANES(LANES), .XLEN(XLEN)) mif ();

    wb_retire_stage #(.LANES(LANES), .XLEN(XLEN), .TRACE_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_wb            (mif),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .WB_to_ID_forward  (WB_to_ID_forward),
        .debug_wb_valid    (debug_wb_valid),
        .debug_wb_ready    (debug_wb_ready),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    int checks = 0;
    int failures = 0;
    rf_t rf_q[$];
    tr_t tr_q[$];
    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic lane_t mk(input logic v, input logic we, input logic [4:0] dest,
                                 input logic [31:0] res, input logic [31:0] pc);
        lane_t l;
        l.v = v; l.we = we; l.dest = dest; l.res = res; l.pc = pc;
        return l;
    endfunction

    // Prediction of what a fired bundle must produce.
    task automatic expect_bundle(input lane_t l0, input lane_t l1, input bit do_rf, input bit do_tr);
        logic w0, w1;
        rf_t r;
        tr_t t;
        w0 = l0.v && l0.we && (l0.dest != 5'd0);
        w1 = l1.v && l1.we && (l1.dest != 5'd0);
        if (w0 && w1 && (l0.dest == l1.dest)) w0 = 1'b0;
        if (do_rf && (w0 || w1)) begin
            r.we = {w1, w0}; r.addr = {l1.dest, l0.dest}; r.data = {l1.res, l0.res};
            rf_q.push_back(r);
        end
        if (do_tr && l0.v) begin
            t.pc = l0.pc; t.we = l0.we && (l0.dest != 5'd0); t.dest = l0.dest; t.res = l0.res;
            tr_q.push_back(t);
        end
        if (do_tr && l1.v) begin
            t.pc = l1.pc; t.we = l1.we && (l1.dest != 5'd0); t.dest = l1.dest; t.res = l1.res;
            tr_q.push_back(t);
        end
    endtask

    // Drive a bundle until accepted; returns at #1 after the accepting edge.
    task automatic send(input lane_t l0, input lane_t l1, input bit do_rf, input bit do_tr,
                        output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        mif.MEM_to_WB_bus   = {l1, l0};
        mif.MEM_to_WB_valid = 1'b1;
        expect_bundle(l0, l1, do_rf, do_tr);
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (mif.WB_allow) acc = 1'b1;
            @(posedge clk); #1;
            if (!acc) waits++;
        end
        chk("send_accepted", 64'(acc), 64'd1);
        mif.MEM_to_WB_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((rf_q.size() != 0 || tr_q.size() != 0 || debug_wb_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rf_left"}, 64'(rf_q.size()), 64'd0);
        chk({tag, "_trace_left"}, 64'(tr_q.size()), 64'd0);
        chk({tag, "_dbg_idle"}, 64'(debug_wb_valid), 64'd0);
    endtask

    // Scoreboard monitors, sampled mid-cycle.
    always @(negedge clk) begin : mon
        rf_t r;
        tr_t t;
        if (resetn) begin
            if (rf_we != '0) begin
                if (rf_q.size() == 0) chk("rf_unexpected_we", 64'(rf_we), 64'd0);
                else begin
                    r = rf_q.pop_front();
                    chk("rf_we", 64'(rf_we), 64'(r.we));
                    for (int i = 0; i < LANES; i++) begin
                        if (r.we[i]) begin
                            chk("rf_waddr", 64'(rf_waddr[i*5 +: 5]), 64'(r.addr[i*5 +: 5]));
                            chk("rf_wdata", 64'(rf_wdata[i*32 +: 32]), 64'(r.data[i*32 +: 32]));
                        end
                    end
                end
            end
            if (debug_wb_valid && debug_wb_ready) begin
                if (tr_q.size() == 0) chk("trace_unexpected", 64'(debug_wb_valid), 64'd0);
                else begin
                    t = tr_q.pop_front();
                    chk("trace_pc", 64'(debug_wb_pc), 64'(t.pc));
                    chk("trace_rf_we", 64'(debug_wb_rf_we), 64'({4{t.we}}));
                    chk("trace_wnum", 64'(debug_wb_rf_wnum), 64'(t.dest));
                    chk("trace_wdata", 64'(debug_wb_rf_wdata), 64'(t.res));
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        int w;
        lane_t z;
        z = '0;
        vt[0] = '{mk(1'b1, 1'b1, 5'd5,  32'h1234, 32'h1c000000), z, 2'b01};
        vt[1] = '{mk(1'b1, 1'b1, 5'd7,  32'h000a, 32'h1c000004),
                  mk(1'b1, 1'b1, 5'd7,  32'h000b, 32'h1c000008), 2'b10};
        vt[2] = '{mk(1'b1, 1'b1, 5'd0,  32'h0055, 32'h1c00000c), z, 2'b00};
        vt[3] = '{z, mk(1'b1, 1'b1, 5'd3, 32'h0033, 32'h1c000010), 2'b10};
        vt[4] = '{mk(1'b1, 1'b0, 5'd9,  32'h0099, 32'h1c000014),
                  mk(1'b1, 1'b1, 5'd10, 32'h00aa, 32'h1c000018), 2'b10};
        vt[5] = '{mk(1'b1, 1'b1, 5'd1,  32'h0111, 32'h1c00001c),
                  mk(1'b1, 1'b1, 5'd2,  32'h0222, 32'h1c000020), 2'b11};
        vt[6] = '{z, z, 2'b00};

        mif.MEM_to_WB_valid = 1'b0;
        mif.MEM_to_WB_bus   = '0;
        mif.WB_flush        = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_dbg_valid", 64'(debug_wb_valid), 64'd0);
        chk("rst_allow", 64'(mif.WB_allow), 64'd1);
        chk("rst_dbg_pc", 64'(debug_wb_pc), 64'd0);
        chk("rst_dbg_we_wnum", 64'({debug_wb_rf_we, debug_wb_rf_wnum}), 64'd0);
        resetn = 1'b1;
        debug_wb_ready = 1'b1;

        // Vector table: one bundle at a time, consumer always ready.
        for (int i = 0; i < 7; i++) begin
            send(vt[i].l0, vt[i].l1, 1'b1, 1'b1, w);
            chk($sformatf("vec%0d_accept_wait", i), 64'(w), 64'd0);
            chk($sformatf("vec%0d_rf_we", i), 64'(rf_we), 64'(vt[i].exp_we));
            if (i == 0) begin
                chk("lat_head_n1", 64'(debug_wb_valid), 64'd0);
                @(posedge clk); #1;
                chk("lat_head_n2", 64'(debug_wb_valid), 64'd1);
                chk("lat_head_pc", 64'(debug_wb_pc), 64'h1c000000);
            end
            if (i == 1) chk("vec1_fwd_lane1", 64'(WB_to_ID_forward[38 +: 38]),
                            64'({1'b1, 5'd7, 32'h000b}));
            drain($sformatf("vec%0d", i));
        end
        chk("empty_dbg_pc", 64'(debug_wb_pc), 64'd0);
        chk("empty_dbg_wdata", 64'(debug_wb_rf_wdata), 64'd0);
        chk("empty_dbg_we_wnum", 64'({debug_wb_rf_we, debug_wb_rf_wnum}), 64'd0);

        // Stall: consumer blocked, two dual bundles fill the FIFO, third waits.
        debug_wb_ready = 1'b0;
        send(mk(1'b1, 1'b1, 5'd11, 32'h1011, 32'h2000_0000), mk(1'b1, 1'b1, 5'd12, 32'h1012, 32'h2000_0004), 1'b1, 1'b1, w);
        send(mk(1'b1, 1'b1, 5'd13, 32'h1013, 32'h2000_0008), mk(1'b1, 1'b1, 5'd14, 32'h1014, 32'h2000_000c), 1'b1, 1'b1, w);
        send(mk(1'b1, 1'b1, 5'd15, 32'h1015, 32'h2000_0010), mk(1'b1, 1'b1, 5'd16, 32'h1016, 32'h2000_0014), 1'b1, 1'b1, w);
        chk("stall_allow", 64'(mif.WB_allow), 64'd0);
        chk("stall_dbg_valid", 64'(debug_wb_valid), 64'd1);
        chk("stall_fwd_dest", 64'(WB_to_ID_forward[32 +: 5]), 64'd15);
        for (int k = 0; k < 3; k++) begin
            chk("stall_rf_we", 64'(rf_we), 64'd0);
            @(posedge clk); #1;
        end
        debug_wb_ready = 1'b1;
        drain("stall");

        // Flush of a stalled bundle.
        debug_wb_ready = 1'b0;
        send(mk(1'b1, 1'b1, 5'd17, 32'h2017, 32'h3000_0000), mk(1'b1, 1'b1, 5'd18, 32'h2018, 32'h3000_0004), 1'b1, 1'b1, w);
        send(mk(1'b1, 1'b1, 5'd19, 32'h2019, 32'h3000_0008), mk(1'b1, 1'b1, 5'd20, 32'h2020, 32'h3000_000c), 1'b1, 1'b1, w);
        send(mk(1'b1, 1'b1, 5'd21, 32'hdead, 32'h3000_0010), mk(1'b1, 1'b1, 5'd22, 32'hbeef, 32'h3000_0014), 1'b0, 1'b0, w);
        chk("pre_flush_allow", 64'(mif.WB_allow), 64'd0);
        mif.WB_flush = 1'b1;
        #1;
        chk("flush_rf_we", 64'(rf_we), 64'd0);
        @(posedge clk); #1;
        mif.WB_flush = 1'b0;
        chk("post_flush_allow", 64'(mif.WB_allow), 64'd1);
        send(mk(1'b1, 1'b1, 5'd23, 32'h2023, 32'h3000_0018), z, 1'b1, 1'b1, w);
        chk("post_flush_accept_wait", 64'(w), 64'd0);
        debug_wb_ready = 1'b1;
        drain("flush");

        // Reset in the middle of a stall with three queued trace entries.
        debug_wb_ready = 1'b0;
        send(mk(1'b1, 1'b1, 5'd24, 32'h3024, 32'h4000_0000), mk(1'b1, 1'b1, 5'd25, 32'h3025, 32'h4000_0004), 1'b1, 1'b0, w);
        send(mk(1'b1, 1'b1, 5'd26, 32'h3026, 32'h4000_0008), z, 1'b1, 1'b0, w);
        send(mk(1'b1, 1'b1, 5'd27, 32'h3027, 32'h4000_000c), mk(1'b1, 1'b1, 5'd28, 32'h3028, 32'h4000_0010), 1'b0, 1'b0, w);
        chk("pre_rst_dbg_valid", 64'(debug_wb_valid), 64'd1);
        chk("pre_rst_allow", 64'(mif.WB_allow), 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_dbg_valid", 64'(debug_wb_valid), 64'd0);
        chk("async_rst_rf_we", 64'(rf_we), 64'd0);
        chk("async_rst_allow", 64'(mif.WB_allow), 64'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        debug_wb_ready = 1'b1;
        chk("rst_rf_q_empty", 64'(rf_q.size()), 64'd0);
        send(mk(1'b1, 1'b1, 5'd29, 32'h3029, 32'h4000_0014), z, 1'b1, 1'b1, w);
        chk("post_rst_accept_wait", 64'(w), 64'd0);
        chk("post_rst_rf_we", 64'(rf_we), 64'd1);
        drain("reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_retire_stage.md
WB_RETIRE_STAGE -- requirements
Module: wb_retire_stage

Interface
REQ-001 Parameter LANES, default 2, number of retire lanes (1..2); lane 0 is the oldest.
REQ-002 Parameter XLEN, default 32, data and PC width.
REQ-003 Parameter TRACE_DEPTH, default 4, debug trace FIFO entries; power of two, >= LANES.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 MEM_to_WB_valid  in  1  MEM bundle valid.
REQ-007 MEM_to_WB_bus  in  LANES*LANE_W  per lane {lane_v, gr_we, dest[4:0], result[XLEN-1:0], pc[XLEN-1:0]}; lane 0 in the LSBs; LANE_W = 2*XLEN+7.
REQ-008 WB_allow  out  1  WB accepts a bundle this cycle.
REQ-009 WB_flush  in  1  discard the held bundle.
REQ-010 rf_we  out  LANES  per-lane register-file write enable.
REQ-011 rf_waddr  out  LANES*5  per-lane write address.
REQ-012 rf_wdata  out  LANES*XLEN  per-lane write data.
REQ-013 WB_to_ID_forward  out  LANES*(6+XLEN)  per lane {gr_we, dest masked by WB_valid, result}.
REQ-014 debug_wb_valid  out  1  trace entry available.
REQ-015 debug_wb_ready  in  1  trace consumer takes the entry.
REQ-016 debug_wb_pc / debug_wb_rf_we[3:0] / debug_wb_rf_wnum[4:0] / debug_wb_rf_wdata  out  trace head fields.

Function
REQ-017 WB_valid is set on an accepted bundle (MEM_to_WB_valid && WB_allow) and cleared when the held bundle fires without a new one arriving, or on WB_flush.
REQ-018 The bundle register loads only on MEM_to_WB_valid && WB_allow.
REQ-019 NV = count of lane_v bits in the held bundle; WB_ready_go = (TRACE_DEPTH - fifo_count) >= NV, using the count before this cycle's pop.
REQ-020 WB_allow = !WB_valid || (WB_ready_go && !WB_flush).
REQ-021 fire = WB_valid && WB_ready_go && !WB_flush; a bundle fires exactly once.
REQ-022 rf_we[i] = fire && lane_v[i] && gr_we[i] && dest[i] != 0.
REQ-023 With both lanes firing to the same nonzero dest, rf_we[0] SHALL be 0 (the younger lane wins).
REQ-024 Forward dest is zero when !WB_valid or !lane_v; forward is valid during stalls.
REQ-025 On fire, each lane_v lane pushes {pc, gr_we && dest != 0, dest, result} into the trace FIFO, lane 0 first, in the same cycle.
REQ-026 Pop occurs on debug_wb_valid && debug_wb_ready; debug_wb_valid = fifo_count != 0.
REQ-027 fifo_count next = count + pushes - pop, with simultaneous push and pop allowed; pointers wrap modulo TRACE_DEPTH.
REQ-028 When the FIFO is empty, all debug_* outputs SHALL be 0; debug_wb_rf_we = {4{entry.we}}.
REQ-029 Latency: bundle accepted at cycle N is written to the RF at N+1 when not stalled; the trace head appears at N+2 at the earliest.
REQ-030 WB_flush drops the held bundle: no RF write and no trace push; FIFO contents are retained.

Reset
REQ-031 Asserting resetn low SHALL asynchronously clear WB_valid, the FIFO pointers, and fifo_count, forcing rf_we = 0 and debug_wb_valid = 0; the bundle and FIFO data registers are not reset.
REQ-032 Reset asserted mid-stall SHALL discard both the held bundle and the queued trace entries.
REQ-033 The first bundle may be accepted on the first clk edge after resetn deasserts.

Structure
REQ-034 Package wb_pkg SHALL hold LANE_W, the lane field offsets, and the trace entry width (3*... = 2*XLEN+6).
REQ-035 Sub-module wb_trace_fifo SHALL implement the multi-push (up to LANES), single-pop FIFO with a count output.

Verification
REQ-036 Single lane: lane0 {we=1, dest=5, result=0x1234, pc=0x1c000000} -> rf_we=01 at N+1; trace head pc 0x1c000000, wnum 5, wdata 0x1234, rf_we=0xF.
REQ-037 Dual lane, same dest 7 (0xA then 0xB) -> rf_we=10, wdata lane1 = 0xB; trace shows the lane0 entry then the lane1 entry, both with we=0xF.
REQ-038 debug_wb_ready held 0, dual-lane bundles streamed -> after 2 bundles the FIFO holds 4, WB_allow=0, no RF writes repeat; releasing ready drains the FIFO in order.
REQ-039 dest=0 with gr_we=1 -> rf_we=0; trace entry has rf_we=0x0.
REQ-040 WB_flush during a stall -> bundle dropped, no RF write and no trace push; the next bundle is accepted the following cycle.
REQ-041 resetn pulsed low mid-stall with the FIFO holding 3 -> debug_wb_valid=0 and rf_we=0 immediately, with no clock edge.
